// File: rtl/mtsp_pc_sequencer.sv
// mtsp_pc_sequencer
//   Per-thread program-counter owner and fetch issuer for the Meitner core.
//   It consumes branch resolutions and external thread commands, and it
//   issues one fetch request per cycle. Requests go round-robin across the
//   threads that are running and have no instruction in flight.
//
// Optional build macro: MTSP_PC_ERR_EN
//   When defined, ERR is a sticky protocol-error flag that clears only on RST.
//   When undefined, ERR is tied low. The datapath behaves the same either way.
//
// Ports
//   CLK          main clock
//   RST          synchronous active-high reset
//   RES_nEN      resolution/command valid (active low)
//   RES_EXT      1 = external thread command, 0 = pipeline resolution
//   RES_TID      target thread
//   RES_BO       branch op: 0 JMP, 1 ALL, 2 END, 3 SEQ (4..15 act as SEQ)
//   RES_PC       next-PC value
//   FETCH_VALID  fetch request valid (registered slot)
//   FETCH_READY  fetch accepted
//   FETCH_TID    thread of the request
//   FETCH_PC     PC of the request
//   THREAD_RUN   registered per-thread run flags
//   ERR          sticky protocol error
module mtsp_pc_sequencer #(
  parameter int THREAD_COUNT = 4,
  parameter int TID_W        = $clog2(THREAD_COUNT),
  parameter int PC_W         = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RES_nEN,
  input  logic                    RES_EXT,
  input  logic [TID_W-1:0]        RES_TID,
  input  logic [3:0]              RES_BO,
  input  logic [PC_W-1:0]         RES_PC,
  output logic                    FETCH_VALID,
  input  logic                    FETCH_READY,
  output logic [TID_W-1:0]        FETCH_TID,
  output logic [PC_W-1:0]         FETCH_PC,
  output logic [THREAD_COUNT-1:0] THREAD_RUN,
  output logic                    ERR
);

  localparam logic [3:0] BO_JMP = 4'd0;
  localparam logic [3:0] BO_ALL = 4'd1;
  localparam logic [3:0] BO_END = 4'd2;
  localparam logic [3:0] BO_SEQ = 4'd3;

  logic [PC_W-1:0]         pc_q [THREAD_COUNT];
  logic [PC_W-1:0]         pc_d [THREAD_COUNT];
  logic [THREAD_COUNT-1:0] run_q, run_d;
  logic [THREAD_COUNT-1:0] pend_q, pend_d;
  logic                    fv_q, fv_d;
  logic [TID_W-1:0]        ftid_q, ftid_d;
  logic [PC_W-1:0]         fpc_q, fpc_d;
  logic [TID_W-1:0]        ptr_q, ptr_d;

  logic                    res_vld;
  logic [THREAD_COUNT-1:0] elig;
  logic                    slot_free;
  logic                    found;
  logic [TID_W-1:0]        sel;

  assign res_vld   = ~RES_nEN;
  // Eligibility is taken from registered state, so a thread released by a
  // resolution becomes selectable one cycle later.
  assign elig      = run_q & ~pend_q;
  assign slot_free = ~fv_q | FETCH_READY;

  // First eligible thread at or after the round-robin pointer; the index
  // wraps naturally because THREAD_COUNT is a power of two.
  always_comb begin : pick
    logic [TID_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < THREAD_COUNT; i++) begin
      idx = ptr_q + TID_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    pc_d   = pc_q;
    run_d  = run_q;
    pend_d = pend_q;
    fv_d   = fv_q;
    ftid_d = ftid_q;
    fpc_d  = fpc_q;
    ptr_d  = ptr_q;

    if (res_vld) begin
      if (!RES_EXT) begin
        // A resolution for a non-pending thread is dropped entirely.
        if (pend_q[RES_TID]) begin
          pend_d[RES_TID] = 1'b0;
          // A thread killed externally only absorbs its stale resolution.
          if (run_q[RES_TID]) begin
            if (RES_BO == BO_ALL) begin
              for (int i = 0; i < THREAD_COUNT; i++) pc_d[i] = RES_PC;
              run_d = '1;
            end else if (RES_BO == BO_JMP) begin
              pc_d[RES_TID] = RES_PC;
            end else if (RES_BO == BO_END) begin
              run_d[RES_TID] = 1'b0;
            end else begin
              // SEQ and every undefined op code
              pc_d[RES_TID] = RES_PC + 1'b1;
            end
          end
        end
      end else begin
        if (RES_BO == BO_ALL) begin
          for (int i = 0; i < THREAD_COUNT; i++) pc_d[i] = RES_PC;
          run_d = '1;
        end else if (RES_BO == BO_JMP) begin
          if (!run_q[RES_TID]) begin
            pc_d[RES_TID]  = RES_PC;
            run_d[RES_TID] = 1'b1;
          end
        end else if (RES_BO == BO_END) begin
          // PENDING stays set so the in-flight resolution is absorbed later.
          run_d[RES_TID] = 1'b0;
        end
      end
    end

    // The selected thread was not pending, so no resolution above touched
    // its PENDING bit and setting it here cannot collide.
    if (slot_free) begin
      fv_d = found;
      if (found) begin
        ftid_d       = sel;
        fpc_d        = pc_q[sel];
        pend_d[sel]  = 1'b1;
        ptr_d        = sel + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < THREAD_COUNT; i++) pc_q[i] <= '0;
      run_q  <= '0;
      pend_q <= '0;
      fv_q   <= 1'b0;
      ftid_q <= '0;
      fpc_q  <= '0;
      ptr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= run_d;
      pend_q <= pend_d;
      fv_q   <= fv_d;
      ftid_q <= ftid_d;
      fpc_q  <= fpc_d;
      ptr_q  <= ptr_d;
    end
  end

  assign FETCH_VALID = fv_q;
  assign FETCH_TID   = ftid_q;
  assign FETCH_PC    = fpc_q;
  assign THREAD_RUN  = run_q;

`ifdef MTSP_PC_ERR_EN
  logic err_q, err_d;
  logic op_undef;
  logic err_set;

  assign op_undef = (RES_BO[3:2] != 2'b00);
  assign err_set  = res_vld & (op_undef
                             | (~RES_EXT & ~pend_q[RES_TID])
                             | (RES_EXT & (RES_BO == BO_SEQ)));

  always_comb err_d = err_q | err_set;

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
